// File: rtl/episode_runner.sv
// rtl/episode_runner.sv - runs one POMDP episode against the state generator and accumulates its reward
module episode_runner #(
    parameter int          NUM_STEPS = 16,
    parameter int          ACC_W     = 24,
    parameter int          TIMEOUT   = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           init_state,
    input  logic [0:1][1:0]                policy_action,
    output logic                           sg_en,
    output logic                           sg_cur_state,
    output logic [1:0]                     sg_action,
    output logic [15:0]                    sg_random,
    input  logic                           sg_valid,
    input  logic                           sg_new_state,
    input  logic [15:0]                    sg_reward,
    output logic                           busy,
    output logic                           done,
    output logic [ACC_W-1:0]               total_reward,
    output logic [$clog2(NUM_STEPS+1)-1:0] steps_done,
    output logic                           final_state,
    output logic                           timeout_err
);

    localparam int SW = $clog2(NUM_STEPS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

    state_t           state_q;
    logic             cur_state_q;
    logic [1:0]       action_q;
    logic [15:0]      lfsr_q;
    logic             busy_q;
    logic             done_q;
    logic [ACC_W-1:0] total_q;
    logic [SW-1:0]    steps_q;
    logic             final_q;
    logic             terr_q;
    logic [TW-1:0]    wcnt_q;

    logic [15:0]      lfsr_d;
    logic [ACC_W:0]   sum_d;
    logic [ACC_W-1:0] total_d;
    logic             last_step_d;

    always_comb begin
        lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        sum_d       = {1'b0, total_q} + (ACC_W + 1)'(sg_reward);
        // Carry out of the accumulator pins the total at all-ones instead of wrapping.
        total_d     = sum_d[ACC_W] ? '1 : sum_d[ACC_W-1:0];
        last_step_d = (32'(steps_q) + 32'd1 == NUM_STEPS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_state_q <= 1'b0;
            action_q    <= 2'd0;
            lfsr_q      <= LFSR_SEED;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            total_q     <= '0;
            steps_q     <= '0;
            final_q     <= 1'b0;
            terr_q      <= 1'b0;
            wcnt_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        final_q     <= init_state;
                        total_q     <= '0;
                        steps_q     <= '0;
                        terr_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        cur_state_q <= init_state;
                        action_q    <= policy_action[init_state];
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    // sg_valid may still be high from the previous answer; it is not looked at here.
                    wcnt_q  <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (sg_valid) begin
                        final_q <= sg_new_state;
                        total_q <= total_d;
                        steps_q <= steps_q + 1'b1;
                        lfsr_q  <= lfsr_d;
                        if (last_step_d) begin
                            state_q <= FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            cur_state_q <= sg_new_state;
                            action_q    <= policy_action[sg_new_state];
                            state_q     <= ISSUE;
                        end
                    end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
                        terr_q  <= 1'b1;
                        state_q <= FINISH;
                        done_q  <= 1'b1;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sg_en        = (state_q == ISSUE);
    assign sg_cur_state = cur_state_q;
    assign sg_action    = action_q;
    assign sg_random    = lfsr_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign total_reward = total_q;
    assign steps_done   = steps_q;
    assign final_state  = final_q;
    assign timeout_err  = terr_q;

endmodule

// File: tb/tb_episode_runner.sv
// tb/tb_episode_runner.sv - scoreboard bench for episode_runner
module tb_episode_runner;

    localparam int NS = 4;
    localparam int AW = 17;
    localparam int TO = 8;

    typedef struct packed {
        logic          cur;
        logic [1:0]    act;
        logic [15:0]   rnd;
    } req_t;

    typedef struct packed {
        logic [AW-1:0] total;
        logic [2:0]    steps;
        logic          fin;
        logic          terr;
        logic [7:0]    lat;
    } ep_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             init_state = 1'b0;
    logic [0:1][1:0]  policy_action = '0;
    logic             sg_en;
    logic             sg_cur_state;
    logic [1:0]       sg_action;
    logic [15:0]      sg_random;
    logic             sg_valid = 1'b0;
    logic             sg_new_state = 1'b0;
    logic [15:0]      sg_reward = 16'd0;
    logic             busy;
    logic             done;
    logic [AW-1:0]    total_reward;
    logic [2:0]       steps_done;
    logic             final_state;
    logic             timeout_err;

    episode_runner #(.NUM_STEPS(NS), .ACC_W(AW), .TIMEOUT(TO), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .rst(rst), .start(start), .init_state(init_state),
        .policy_action(policy_action), .sg_en(sg_en), .sg_cur_state(sg_cur_state),
        .sg_action(sg_action), .sg_random(sg_random), .sg_valid(sg_valid),
        .sg_new_state(sg_new_state), .sg_reward(sg_reward), .busy(busy), .done(done),
        .total_reward(total_reward), .steps_done(steps_done), .final_state(final_state),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          start_cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    bit          stale = 1'b0;
    logic [15:0] lfsr_m = 16'hACE1;
    req_t        req_q[$];
    ep_t         ep_q[$];
    logic [16:0] resp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] lfsr_nx(input logic [15:0] r);
        return {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Generator model: answers one cycle after each sg_en while it has queued responses.
    initial begin : responder
        logic [16:0] r;
        forever begin
            @(negedge clk);
            if (sg_en && !rst && resp_q.size() != 0) begin
                r = resp_q.pop_front();
                @(posedge clk); #1;
                sg_valid     = 1'b1;
                sg_new_state = r[16];
                sg_reward    = r[15:0];
                @(posedge clk); #1;
                sg_valid = stale;
            end else begin
                sg_valid = stale;
            end
        end
    end

    initial begin : monitor
        req_t r;
        ep_t  e;
        forever begin
            @(negedge clk);
            if (!rst && sg_en) begin
                if (req_q.size() == 0) chk("unexpected_sg_en", 32'd1, 32'd0);
                else begin
                    r = req_q.pop_front();
                    chk("sg_cur_state", 32'(sg_cur_state), 32'(r.cur));
                    chk("sg_action", 32'(sg_action), 32'(r.act));
                    chk("sg_random", 32'(sg_random), 32'(r.rnd));
                end
            end
            if (!rst && done) begin
                done_cnt++;
                if (ep_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else begin
                    e = ep_q.pop_front();
                    chk("total_reward", 32'(total_reward), 32'(e.total));
                    chk("steps_done", 32'(steps_done), 32'(e.steps));
                    chk("final_state", 32'(final_state), 32'(e.fin));
                    chk("timeout_err", 32'(timeout_err), 32'(e.terr));
                    chk("done_latency", 32'(cyc - start_cyc), 32'(e.lat));
                    chk("busy_at_done", 32'(busy), 32'd1);
                end
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_ep(input logic ini, input logic [0:1][1:0] pol, input logic [63:0] rw,
                          input logic [3:0] st, input bit to_mode, input bit stale_m,
                          input bit busy_start, input logic [AW-1:0] exp_total, input logic exp_fin);
        logic cur;
        int   d0;
        ep_t  e;
        cur = ini;
        policy_action = pol;
        init_state    = ini;
        for (int k = 0; k < (to_mode ? 1 : NS); k++) begin
            req_q.push_back('{cur: cur, act: pol[cur], rnd: lfsr_m});
            if (!to_mode) begin
                resp_q.push_back({st[k], rw[16*k +: 16]});
                lfsr_m = lfsr_nx(lfsr_m);
                cur    = st[k];
            end
        end
        e.total = exp_total;
        e.steps = to_mode ? 3'd0 : 3'(NS);
        e.fin   = exp_fin;
        e.terr  = to_mode;
        e.lat   = to_mode ? 8'(2 + TO) : 8'(2 * NS + 1);
        ep_q.push_back(e);
        stale = stale_m;
        @(posedge clk);
        d0 = done_cnt;
        pulse_start();
        if (busy_start) begin
            @(posedge clk); @(posedge clk); #1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        for (int i = 0; i < 100 && done_cnt == d0; i++) @(posedge clk);
        if (done_cnt == d0) chk("done_wait_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        chk("busy_after_done", 32'(busy), 32'd0);
        stale = 1'b0;
        @(posedge clk);
    endtask

    initial begin : main
        logic cur;
        bit   seen;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic cur;
        bit   seen;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sg_en", 32'(sg_en), 32'd0);
        chk("rst_total", 32'(total_reward), 32'd0);
        chk("rst_random", 32'(sg_random), 32'hACE1);
        rst = 1'b0;

        run_ep(1'b0, {2'd2, 2'd1}, {16'h1000, 16'h0001, 16'h0100, 16'h0010}, 4'b1011,
               1'b0, 1'b0, 1'b0, 17'h01111, 1'b1);
        run_ep(1'b1, {2'd3, 2'd0}, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 4'b0010,
               1'b0, 1'b0, 1'b0, 17'h1FFFF, 1'b0);
        run_ep(1'b1, {2'd1, 2'd3}, 64'd0, 4'b0000, 1'b1, 1'b0, 1'b0, 17'h0, 1'b1);
        run_ep(1'b0, {2'd0, 2'd2}, {16'h0008, 16'h0007, 16'h0006, 16'h0005}, 4'b1100,
               1'b0, 1'b0, 1'b0, 17'h0001A, 1'b1);
        run_ep(1'b0, {2'd1, 2'd2}, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, 4'b0101,
               1'b0, 1'b1, 1'b1, 17'h0000A, 1'b0);

        // Abort an episode in WAIT after three completed steps.
        policy_action = {2'd1, 2'd2};
        init_state    = 1'b1;
        cur = 1'b1;
        for (int k = 0; k < NS; k++) begin
            req_q.push_back('{cur: cur, act: policy_action[cur], rnd: lfsr_m});
            if (k < 3) begin
                resp_q.push_back({~cur, 16'h0100});
                lfsr_m = lfsr_nx(lfsr_m);
                cur    = ~cur;
            end
        end
        pulse_start();
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = (steps_done == 3'd3);
        end
        chk("reach_step3", 32'(seen), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("arst_sg_en", 32'(sg_en), 32'd0);
        chk("arst_cur", 32'(sg_cur_state), 32'd0);
        chk("arst_act", 32'(sg_action), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_total", 32'(total_reward), 32'd0);
        chk("arst_steps", 32'(steps_done), 32'd0);
        chk("arst_final", 32'(final_state), 32'd0);
        chk("arst_terr", 32'(timeout_err), 32'd0);
        chk("arst_random", 32'(sg_random), 32'hACE1);
        chk("arst_req_left", 32'(req_q.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        lfsr_m = 16'hACE1;

        run_ep(1'b1, {2'd3, 2'd2}, {16'h0010, 16'h0010, 16'h0010, 16'h0010}, 4'b1111,
               1'b0, 1'b0, 1'b0, 17'h00040, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        chk("done_count", 32'(done_cnt), 32'd6);
        chk("req_q_empty", 32'(req_q.size()), 32'd0);
        chk("ep_q_empty", 32'(ep_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
